// File: rtl/mem_access_unit_if.sv
// Request/response bus between the CPU datapath (master) and mem_access_unit (slave).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator for a word-indexed data memory; sub-word stores use read-modify-write.
// Optional feature: define MAU_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 32'd599
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_write_data,
  output logic                mem_write,
  output logic                mem_read,
  input  logic [31:0]         mem_read_data
);

  typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10, RESP = 2'b11} state_t;

  state_t      state_r;
  state_t      state_s;
  logic        write_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  lane_r;
  logic [29:0] idx_r;
  logic [31:0] wdata_r;
  logic [31:0] word_r;
  logic        err_r;
  logic        accept_s;
  logic        oob_s;
  logic        err_s;

  // Selected lane shifted down to bit 0, then zero- or sign-extended.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
    logic [31:0] sh_w;
    logic [31:0] res;
    sh_w = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = {{24{sgn & sh_w[7]}}, sh_w[7:0]};
      2'b01:   res = {{16{sgn & sh_w[15]}}, sh_w[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (word & ~(mask << {lane, 3'b000})) | ((wdata & mask) << {lane, 3'b000});
  endfunction

  assign accept_s = bus.req_valid && (state_r == IDLE);

`ifdef MAU_BOUNDS_CHECK_EN
  assign oob_s = ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
`else
  // MEM_WORDS has no effect when the range check is compiled out.
  assign oob_s = 1'b0 && ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
`endif

  // Alignment, size and range check on the incoming request.
  always_comb begin
    err_s = oob_s;
    case (bus.req_size)
      2'b00:   err_s = oob_s;
      2'b01:   err_s = oob_s | bus.req_addr[0];
      2'b10:   err_s = oob_s | (bus.req_addr[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                                  state_s = IDLE;
        else if (err_s)                                 state_s = RESP;
        else if (bus.req_write && bus.req_size == 2'b10) state_s = WR;
        else                                            state_s = RD;
      end
      RD: begin
        if (write_r) state_s = WR;
        else         state_s = RESP;
      end
      WR:      state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and read capture register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      write_r  <= 1'b0;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      lane_r   <= 2'b00;
      idx_r    <= 30'd0;
      wdata_r  <= 32'd0;
      word_r   <= 32'd0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        write_r  <= bus.req_write;
        size_r   <= bus.req_size;
        signed_r <= bus.req_signed;
        lane_r   <= bus.req_addr[1:0];
        idx_r    <= bus.req_addr[31:2];
        wdata_r  <= bus.req_wdata;
        err_r    <= err_s;
      end
      if (state_r == RD) begin
        word_r <= mem_read_data;
      end
    end
  end

  // Outputs decode from registered state and the latched request only.
  always_comb begin
    bus.req_ready  = (state_r == IDLE);
    mem_read       = (state_r == RD);
    mem_write      = (state_r == WR);
    mem_address    = {2'b00, idx_r};
    mem_write_data = 32'd0;
    if (state_r == WR) begin
      if (size_r == 2'b10) mem_write_data = wdata_r;
      else                 mem_write_data = merge_lane(word_r, wdata_r, size_r, lane_r);
    end else begin
      mem_write_data = 32'd0;
    end
    bus.resp_valid = (state_r == RESP);
    bus.resp_err   = (state_r == RESP) && err_r;
    bus.resp_rdata = 32'd0;
    if ((state_r == RESP) && !err_r && !write_r) begin
      bus.resp_rdata = extract_lane(word_r, size_r, lane_r, signed_r);
    end else begin
      bus.resp_rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses, a monitor pops and compares.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic [31:0] mem [0:1023];
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t q[$];

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: response scoreboard plus read/write exclusivity.
  always @(negedge clk) begin
    exp_t e;
    chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
    if (bus.resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
        chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input logic [31:0] exp_wd, input string nm);
    exp_t e;
    int   k;
    logic sub;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sub = w && (sz != 2'b10);
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc;
    e.lat   = exp_err ? 1 : (sub ? 3 : 2);
    e.name  = nm;
    q.push_back(e);
    if (exp_err) begin
      chk({nm, "_noaccess"}, {30'd0, mem_read, mem_write}, 32'd0);
    end else if (w && !sub) begin
      chk({nm, "_t1_wr"}, {30'd0, mem_read, mem_write}, 32'd1);
      chk({nm, "_t1_addr"}, mem_address, a >> 2);
      chk({nm, "_t1_wdata"}, mem_write_data, wd);
    end else begin
      chk({nm, "_t1_rd"}, {30'd0, mem_read, mem_write}, 32'd2);
      chk({nm, "_t1_addr"}, mem_address, a >> 2);
    end
    if (!exp_err && sub) begin
      @(posedge clk);
      #1;
      chk({nm, "_t2_wr"}, {30'd0, mem_read, mem_write}, 32'd1);
      chk({nm, "_t2_wdata"}, mem_write_data, exp_wd);
    end
    k = 0;
    while (!bus.req_ready && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.req_ready) chk({nm, "_ready_timeout"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5]   = 32'h8899_AABB;
    mem[598] = 32'h5EED_0598;
    mem[600] = 32'h600D_600D;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_strobes", {29'd0, bus.resp_valid, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);

    send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h8899_AABB, 1'b0, 32'd0, "lw_14");
    send(1'b0, 2'b00, 1'b1, 32'h14, 32'd0, 32'hFFFF_FFBB, 1'b0, 32'd0, "lb_14");
    send(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 32'h0000_0088, 1'b0, 32'd0, "lbu_17");
    send(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'hFFFF_8899, 1'b0, 32'd0, "lh_16");
    send(1'b0, 2'b01, 1'b0, 32'h14, 32'd0, 32'h0000_AABB, 1'b0, 32'd0, "lhu_14");
    send(1'b0, 2'b00, 1'b1, 32'h15, 32'd0, 32'hFFFF_FFAA, 1'b0, 32'd0, "lb_15");
    send(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_0011, 32'd0, 1'b0, 32'h8899_11BB, "sb_15");
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h8899_11BB, 1'b0, 32'd0, "lw_after_sb");
    send(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1234, 32'd0, 1'b0, 32'h1234_11BB, "sh_16");
    send(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, 32'd0, 1'b0, 32'd0, "sw_18");
    send(1'b0, 2'b10, 1'b1, 32'h18, 32'd0, 32'hCAFE_F00D, 1'b0, 32'd0, "lw_18");
    send(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 32'd0, "lh_misalign");
    send(1'b0, 2'b11, 1'b0, 32'h14, 32'd0, 32'd0, 1'b1, 32'd0, "size11");
    send(1'b0, 2'b10, 1'b0, 32'h16, 32'd0, 32'd0, 1'b1, 32'd0, "lw_misalign");
    send(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_BEEF, 32'd0, 1'b1, 32'd0, "sh_misalign");
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h1234_11BB, 1'b0, 32'd0, "lw_after_err");
    send(1'b0, 2'b10, 1'b0, 32'h958, 32'd0, 32'h5EED_0598, 1'b0, 32'd0, "lw_598");
`ifdef MAU_BOUNDS_CHECK_EN
    send(1'b0, 2'b10, 1'b0, 32'h960, 32'd0, 32'd0, 1'b1, 32'd0, "lw_600_oob");
`else
    send(1'b0, 2'b10, 1'b0, 32'h960, 32'd0, 32'h600D_600D, 1'b0, 32'd0, "lw_600");
`endif

    // Reset during the RD phase of a byte store drops the request.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rst_mid_rd", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_nowrite", {30'd0, mem_write, bus.resp_valid}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h14;
    @(posedge clk);
    #1;
    chk("rst_req_ignored", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mem5_kept", mem[5], 32'h1234_11BB);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write_later", mem[5], 32'h1234_11BB);
    send(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 32'h0000_0012, 1'b0, 32'd0, "lbu_after_rst");

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting between the CPU datapath and the word-addressed `data_memory` port. It converts byte-addressed, size-qualified load/store requests (byte, halfword, word; signed or unsigned loads) into word-index `address`/`write_data`/`mem_write`/`mem_read` cycles. Sub-word stores are done as read-modify-write. Results and errors are returned through a one-cycle response pulse.

## Interface
Parameters:
- `MEM_WORDS`, default 599 (0x257): number of words in the attached data memory. Used only by the bounds check.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle. A request is accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  sign-extend sub-word loads. Ignored for stores and word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned in bits [7:0] or [15:0] for sub-word stores.
- `resp_valid`  out  1  one-cycle pulse when the request completes.
- `resp_rdata`  out  32  load result. 0 for stores and errors.
- `resp_err`  out  1  request rejected; valid only with `resp_valid`.
- `mem_address`  out  32  word index, `req_addr >> 2`.
- `mem_write_data`  out  32  word written to memory.
- `mem_write`  out  1  memory write strobe.
- `mem_read`  out  1  memory read strobe.
- `mem_read_data`  in  32  combinational read data from memory.

## Operation
- The request is latched on acceptance. Memory-side outputs decode from the state register and the latched request only; there is no combinational path from `req_*` to `mem_*`.
- Lane mapping is little-endian within the word:
  - byte lane `addr[1:0]` occupies bits [8*k+7 : 8*k];
  - halfword `addr[1]` occupies bits [16*h+15 : 16*h].
- Error check at acceptance. Any of the following gives an error:
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]!=0`;
  - `req_size=11`;
  - bounds violation (see Configuration).
  An erroring request makes no memory access.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE → RESP on error.
  - IDLE → WR for a word store.
  - IDLE → RD for a load or sub-word store.
  - RD → WR for a sub-word store.
  - RD → RESP for a load.
  - WR → RESP.
  - RESP → IDLE.
- RD: `mem_read=1`. `mem_read_data` is captured into a word register at the end of the cycle.
- WR: `mem_write=1`.
  - Word store: `mem_write_data = req_wdata`.
  - Sub-word store: `mem_write_data` is the captured word with the selected lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
- Load extraction: the selected lane is shifted to bit 0, then zero- or sign-extended per `req_signed`.
- `req_ready=1` only in IDLE. `req_valid` in any other state is ignored; the requester holds the request.
- `mem_address` holds the latched word index from the cycle after acceptance until IDLE is re-entered, then holds its last value. `mem_read` and `mem_write` are never asserted together.

## Timing
Acceptance happens at edge T. All latencies are counted from that edge.
- Error: `resp_valid`/`resp_err` in cycle T+1.
- Load: RD in T+1, response in T+2.
- Word store: WR in T+1, response in T+2.
- Sub-word store: RD in T+1, WR in T+2, response in T+3.
- Earliest next acceptance: the edge ending the RESP cycle.
- Reset values: state IDLE, `req_ready=1`, and all other outputs 0, including the capture register.
- Reset mid-operation: the in-flight request is dropped. No `mem_write` is issued on or after the reset edge, and no `resp_valid` is issued for the dropped request.
- `rst_n` low with `req_valid` high: the request is not accepted.

## Configuration
- `MAU_BOUNDS_CHECK_EN` defined: a request with `req_addr >> 2` ≥ `MEM_WORDS` is an error, with response at T+1 and no memory access.
- `MAU_BOUNDS_CHECK_EN` undefined: no range check. The word index is passed through unchanged, and `MEM_WORDS` is unused.

## Test plan
Preload memory word 5 with 0x8899AABB unless stated otherwise.
- Word load at addr 0x14 → at T+1, `mem_read=1` with `mem_address=5`; at T+2, `resp_valid=1`, `resp_rdata=0x8899AABB`, `resp_err=0`.
- Sub-word loads:
  - signed byte at addr 0x14 → 0xFFFFFFBB;
  - unsigned byte at 0x17 → 0x00000088;
  - signed half at 0x16 → 0xFFFF8899;
  - unsigned half at 0x14 → 0x0000AABB.
- Byte store at addr 0x15, `req_wdata=0x11` → T+1 RD of word 5; T+2 `mem_write=1`, `mem_write_data=0x889911BB`; T+3 `resp_valid=1`. A following word load returns 0x889911BB.
- Misalignment:
  - half load at addr 0x13 → `resp_err=1` at T+1, with `mem_read` and `mem_write` never asserted;
  - `req_size=11` → same result.
- `rst_n=0` during RD of a byte store → `mem_write` stays 0 and no `resp_valid` is issued. After reset release, `req_ready=1` and memory word 5 is unchanged.
- Bounds, word load at addr 0x960 (word 600):
  - with `MAU_BOUNDS_CHECK_EN` → `resp_err=1` at T+1 and no `mem_read`;
  - without it → `mem_read=1` with `mem_address=600` at T+1.
